// File: rtl/mem_scan_pkg.sv
// Shared types and constants for the RAM scan reader: FSM state encoding,
// default geometry and the scanned word count.
package mem_scan_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEF_DATA_WIDTH = 4;

  function automatic int unsigned word_count(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  localparam int unsigned DEF_WORD_COUNT = word_count(DEF_ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/out_hold_reg.sv
// Output holding register for the scan reader: captures one word and its
// address on load and holds both until the next load.
module out_hold_reg #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // NOTE: this register is reset (not left as uninitialised storage) because
  // the display path must see out_data/out_addr = 0 right after reset; state
  // updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      addr_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      addr_q <= addr_i;
    end
  end

  assign data_o = data_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/mem_scan_reader.sv
// Sequential RAM reader: on start, reads every address once and offers each
// word on a valid/ready port. Optional checksum: MEM_SCAN_READER_CHECKSUM_EN.
module mem_scan_reader
  import mem_scan_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(word_count(ADDR_WIDTH) - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_en_q, valid_q, busy_q, done_q;
  logic                  start_acc;
  logic                  xfer;
  logic                  load;

  assign start_acc = (state_q == IDLE) && start;
  assign xfer      = (state_q == SEND) && out_ready;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ:  state_d = WAIT;
      WAIT: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
            state_d = REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they leave flops
  // aligned with the state they describe.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_en_q <= (state_d == REQ);
      valid_q <= (state_d == SEND);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  out_hold_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_out_hold_reg (
    .clk_2  (clk_2),
    .rst_n  (rst_n),
    .load_i (load),
    .data_i (rd_data),
    .addr_i (cnt_q),
    .data_o (out_data),
    .addr_o (out_addr)
  );

`ifdef MEM_SCAN_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc) begin
      csum_d = '0;
    end else if (xfer) begin
      csum_d = csum_q ^ out_data;
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign rd_en     = rd_en_q;
  assign rd_addr   = cnt_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Self-checking bench for mem_scan_reader: table-driven full scans plus
// hand-written backpressure and mid-scan reset sequences.
module tb_mem_scan_reader;

  localparam int AW = 2;
  localparam int DW = 4;
  localparam int ROWS = 14;

`ifdef MEM_SCAN_READER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk_2;
  logic          rst_n;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ram [4];

  mem_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_2     (clk_2),
    .rst_n     (rst_n),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // RAM model with one cycle of read latency.
  always @(posedge clk_2) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  typedef struct {
    logic          rdy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] oaddr;
    logic          busy;
    logic          done;
    logic [DW-1:0] cs;
  } vec_t;

  vec_t tbl [ROWS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  function automatic logic [31:0] snap();
    logic [AW-1:0] a;
    a = rd_en ? rd_addr : '0;
    return 32'({rd_en, a, out_valid, out_data, out_addr, busy, done, checksum});
  endfunction

  function automatic logic [31:0] pack_row(input vec_t v, input logic [DW-1:0] d,
                                           input logic [AW-1:0] oa);
    logic [DW-1:0] cs;
    cs = CS_EN ? v.cs : '0;
    return 32'({v.rd_en, v.rd_addr, v.valid, d, oa, v.busy, v.done, cs});
  endfunction

  // Full scan with out_ready per table row; start is redriven on rows in
  // start_mask. Rows 0 and 1 still show the previously held word.
  task automatic run_table(input string tag, input logic [ROWS-1:0] start_mask,
                           input logic [DW-1:0] pdata, input logic [AW-1:0] paddr);
    logic [DW-1:0] d;
    logic [AW-1:0] oa;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int e = 0; e < ROWS; e++) begin
      if (e > 0) tick();
      d  = (e < 2) ? pdata : tbl[e].data;
      oa = (e < 2) ? paddr : tbl[e].oaddr;
      check($sformatf("%s_edge%0d", tag, e), snap(), pack_row(tbl[e], d, oa));
      start     = start_mask[e];
      out_ready = tbl[e].rdy;
    end
    start = 1'b0;
  endtask

  initial begin
    int  e;
    bit  found;

    ram[0] = 4'h3; ram[1] = 4'hA; ram[2] = 4'h5; ram[3] = 4'hF;
    //            rdy rd_en addr valid data  oaddr busy done cs
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 4'h3, 2'd0, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 4'h3, 2'd0, 1'b1, 1'b0, 4'h3};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'h3, 2'd0, 1'b1, 1'b0, 4'h3};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b0, 4'h3};
    tbl[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 4'hA, 2'd1, 1'b1, 1'b0, 4'h9};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'hA, 2'd1, 1'b1, 1'b0, 4'h9};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b1, 4'h5, 2'd2, 1'b1, 1'b0, 4'h9};
    tbl[9]  = '{1'b1, 1'b1, 2'd3, 1'b0, 4'h5, 2'd2, 1'b1, 1'b0, 4'hC};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'h5, 2'd2, 1'b1, 1'b0, 4'hC};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b1, 4'hF, 2'd3, 1'b1, 1'b0, 4'hC};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'hF, 2'd3, 1'b1, 1'b1, 4'h3};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'hF, 2'd3, 1'b0, 1'b0, 4'h3};

    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("reset_state", snap(), 32'h0);
    rst_n = 1'b1;
    tick();

    // Plain scan from reset.
    run_table("scan1", 14'b0, 4'h0, 2'd0);

    // start redriven in REQ (row 3), SEND (row 5) and DONE (row 12): ignored.
    run_table("scan_start_ign", 14'b01_0000_0010_1000, 4'hF, 2'd3);

    // Backpressure: stall word 1 in SEND for 5 cycles.
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("bp_send_w1", 32'({out_valid, out_data, out_addr}), 32'({1'b1, 4'hA, 2'd1}));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_stall%0d", i), 32'({out_valid, out_data, out_addr, rd_en}),
            32'({1'b1, 4'hA, 2'd1, 1'b0}));
    end
    out_ready = 1'b1;
    e = 10;
    found = 1'b0;
    while (e < 40 && !found) begin
      tick();
      e++;
      if (done) found = 1'b1;
    end
    check("bp_done_edge", 32'(e), 32'd17);
    check("bp_checksum", 32'(checksum), CS_EN ? 32'h3 : 32'h0);
    tick();
    check("bp_idle", 32'({busy, done}), 32'h0);

    // Reset while word 2 is in SEND.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("pre_rst_send_w2", 32'({out_valid, out_data, out_addr}), 32'({1'b1, 4'h5, 2'd2}));
    rst_n = 1'b0;
    #1;
    check("mid_scan_reset", snap(), 32'h0);
    #3;
    rst_n = 1'b1;
    run_table("scan_after_rst", 14'b0, 4'h0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_scan_reader.md
# mem_scan_reader

Sequential reader for the small switch-written RAM (2**ADDR_WIDTH words × DATA_WIDTH bits) in the board top. When `start` is pulsed, it walks every address from 0 to the last. For each address it issues a synchronous read request and presents the returned word on a valid/ready output port. That port feeds the LED/SEG/LCD display path. It sits between the RAM's read port and the display logic, and is the read-side counterpart of the switch-driven writer.

## Interface
- ADDR_WIDTH, 2, RAM address width; the block scans 2**ADDR_WIDTH words.
- DATA_WIDTH, 4, RAM word width.
- clk_2  input  1  single clock; every flop is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a scan; sampled only in IDLE.
- rd_en  output  1  read request to the RAM.
- rd_addr  output  ADDR_WIDTH  read address; meaningful only while rd_en=1.
- rd_data  input  DATA_WIDTH  RAM read data; valid one cycle after the rd_en cycle.
- out_valid  output  1  out_data/out_addr hold a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_WIDTH  word read.
- out_addr  output  ADDR_WIDTH  address of out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word transfers.
- checksum  output  DATA_WIDTH  XOR of the words transferred in the current/last scan.

## Operation
- FSM states: IDLE, REQ, WAIT, SEND, DONE.
- IDLE: if start=1, clear the address counter and checksum, then go to REQ. Otherwise stay in IDLE.
- REQ: drive rd_en=1 and rd_addr=counter for exactly one cycle, then go to WAIT.
- WAIT: capture rd_data into out_data and the counter into out_addr at the end of the cycle, then go to SEND.
- SEND: out_valid=1. out_data and out_addr are held stable until a transfer (out_valid & out_ready at a rising edge).
  - On transfer, the checksum is XORed with out_data.
  - If the counter equals 2**ADDR_WIDTH-1, go to DONE.
  - Otherwise increment the counter and go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- start is ignored in every state except IDLE, including DONE; it has no queueing.
- The counter never wraps mid-scan. The last address ends the scan.
- checksum keeps its final value until the next accepted start.
- rd_en is 0 in every state except REQ. The RAM must not be written during a scan; this is the environment's responsibility.

## Timing
- Reset values: FSM=IDLE; rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, checksum=0.
- Reset mid-scan (any state) returns immediately to the reset values. No pending word is delivered.
- Edge counting: the start-sampling edge is edge 0.
  - REQ occupies the cycle after edge 0.
  - out_valid rises after edge 2.
- With out_ready held at 1, each word takes 3 cycles. done is high in the cycle after edge 3·N (N=2**ADDR_WIDTH), i.e. after edge 12 for the defaults.
- Each cycle of out_ready=0 in SEND adds one cycle. The next REQ follows the transfer edge directly.
- busy rises after edge 0 and falls after the edge that ends DONE.
- All outputs are registered. There is no combinational path from out_ready to out_valid.

## Configuration
- Macro: MEM_SCAN_READER_CHECKSUM_EN.
- Defined: checksum behaves as described above.
- Undefined: the checksum register is not built and the checksum port is tied to 0. All other behaviour and timing are unchanged.

## Structure
- Package mem_scan_pkg holds:
  - the state enum (IDLE, REQ, WAIT, SEND, DONE);
  - default ADDR_WIDTH/DATA_WIDTH constants;
  - a localparam for the word count.
- One sub-module is natural: out_hold_reg. It contains the DATA_WIDTH+ADDR_WIDTH output holding register with load enable, written in WAIT and held through SEND.
- The FSM and counter stay in mem_scan_reader.

## Test plan
- Bench RAM model has a 1-cycle read latency and contents {4'h3,4'hA,4'h5,4'hF}. With out_ready=1 and a start pulse:
  - out_data is 3,A,5,F with out_addr 0..3;
  - done pulses after edge 12;
  - checksum=4'h3.
- Backpressure: out_ready=0 for 5 cycles while word 1 is in SEND.
  - out_valid stays 1 and out_data stays 4'hA.
  - No rd_en is issued during the stall.
  - done arrives 5 cycles later (after edge 17).
- start pulsed in REQ, SEND and DONE: no restart and no sequence disturbance. A start in IDLE after done repeats the full scan with checksum restarted from 0.
- rst_n asserted during SEND of word 2: all outputs are 0 immediately. A new start then scans from address 0.
- Macro undefined: the same stimulus as scenario 1 gives an identical data sequence and timing, with checksum constantly 0.
